control_stack: RTL and testbench
================================

# control_stack

Control-frame stack and branch sequencer for the wasm CPU. Tracks nested `block`/`loop`/`if` frames, resolves `else`, `end` and `br n` into PC and operand-stack-pointer updates, and raises control-flow traps. Sits beside the decoder in `cpu`. It takes one command per structured-control opcode and returns the jump target and operand-stack restore point the datapath must apply.

## Interface
- `DEPTH_BITS`, 4: log2 of frame capacity (16 frames).
- `PC_WIDTH`, 16: ROM byte-address width.
- `SP_WIDTH`, 8: operand-stack pointer width.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 3: `CTRL_BLOCK`=0, `CTRL_LOOP`=1, `CTRL_IF`=2, `CTRL_ELSE`=3, `CTRL_END`=4, `CTRL_BR`=5.
- `cmd_cond` in 1: popped i32 is non-zero (used by `CTRL_IF`).
- `cmd_pc` in PC_WIDTH: frame continuation. For `loop`, the loop start; for `block`/`if`, the address of the matching `end` opcode.
- `cmd_else_pc` in PC_WIDTH: for `if`, the first instruction after `else`, or equal to `cmd_pc` when there is no else.
- `cmd_sp` in SP_WIDTH: operand-stack pointer at frame entry.
- `cmd_type` in 2: block result type (`i32`/`i64`/`f32`/`f64`).
- `cmd_has_result` in 1: block yields one value.
- `cmd_depth` in DEPTH_BITS: `br` label index.
- `resp_valid` out 1: one-cycle pulse.
- `resp_jump` out 1: the datapath loads `resp_pc`.
- `resp_pc` out PC_WIDTH: jump target.
- `resp_sp` out SP_WIDTH: restore operand stack to this pointer, then re-push the result if `resp_has_result`.
- `resp_type` out 2: result type.
- `resp_has_result` out 1: one value is carried across the restore.
- `depth` out DEPTH_BITS+1: current frame count.
- `trap` out 4: control trap code; 0 = none.

## Operation
- A frame holds {kind[2], pc, sp, type, has_result}.
- State machine:
  - IDLE accepts commands.
  - UNWIND pops frames for `br`.
  - HALT is entered on any nonzero trap.
  - Exits from HALT only via reset.
- `block`/`loop`: push frame; response `resp_jump`=0.
- `if`, `cmd_cond`=1: push; `resp_jump`=0.
- `if`, `cmd_cond`=0: push; `resp_jump`=1, `resp_pc`=`cmd_else_pc`. When this target is the `end` opcode, the subsequent END pops the frame.
- `else`: top must be an IF frame. Response jumps to the frame pc (its `end`); the frame is kept.
- `end` at depth>0: pop; `resp_jump`=0, `resp_sp`/`resp_type`/`resp_has_result` taken from the popped frame.
- `end` at depth 0: function end; `trap`=`ENDED`, go to HALT.
- `br n`: enter UNWIND and pop n frames, one per cycle. The target frame is not popped.
  - LOOP target: jump to its start; `resp_has_result`=0.
  - BLOCK/IF target: jump to its `end`, which pops it; `resp_has_result` comes from the frame.
  - In all cases `resp_sp`=frame sp.
- Traps (with `CONTROL_STACK_CHECK_EN`):
  - push at depth = 2^DEPTH_BITS → `CTRL_OVERFLOW`.
  - `else` with empty stack or non-IF top → `CTRL_BAD_ELSE`.
  - `br n` with n ≥ depth → `CTRL_BAD_LABEL`.
  - Checked on acceptance; the stack is unchanged and no `resp_valid` is issued.

## Timing
- Reset values: `cmd_ready`=0, `resp_*`=0, `depth`=0, `trap`=0, state IDLE.
- `cmd_ready` rises the first cycle after `reset` falls.
- Push/else/end latency: accepted in cycle t → `resp_valid` in t+1. `cmd_ready` stays 1, giving back-to-back throughput of 1/cycle.
- `br n` latency: `resp_valid` in t+1+n. `cmd_ready`=0 from t+1 until the response cycle, inclusive.
- `depth` updates in the same cycle as `resp_valid` (push/end) or decrements each UNWIND cycle.
- `trap` is registered: it is valid in t+1, sticky, and forces `cmd_ready`=0.
- Reset asserted mid-UNWIND aborts the unwind: the stack empties and no response is issued.

## Configuration
- `CONTROL_STACK_CHECK_EN` defined: all `CTRL_*` traps are active as above.
- Undefined: no checks.
  - Overflow wraps the pointer, overwriting frame 0.
  - `else` jumps to the top frame pc regardless of kind.
  - `br` unwinds modulo capacity.
  - Only `ENDED` can be reported.

## Structure
- `cpu.vh` holds the `CTRL_*` opcode defines, frame-kind defines, and the trap codes `CTRL_OVERFLOW`, `CTRL_BAD_ELSE`, `CTRL_BAD_LABEL` alongside the existing `ENDED` and value types.
- Sub-module `control_frame_ram`: 2^DEPTH_BITS-entry register array with one write port (push) and one asynchronous read port (top/unwind index).

## Test plan
- Push `if` with cmd_pc=0x20, else_pc=0x18, sp=3, cond=0 → t+1 `resp_jump`=1, `resp_pc`=0x18, `depth`=1; then `else` → `resp_pc`=0x20; then `end` → `resp_sp`=3, `depth`=0.
- `block`(pc=0x40, sp=1, i32, result) then `loop`(pc=0x10, sp=2) then `br 1` → `resp_valid` exactly 2 cycles after accept, `resp_pc`=0x40, `resp_sp`=1, `resp_has_result`=1, `resp_type`=`i32`, `depth`=1.
- `loop`(pc=0x10, sp=2) then `br 0` → response next cycle, `resp_pc`=0x10, `resp_has_result`=0, `depth`=1.
- `end` at depth 0 → `trap`=`ENDED`, `cmd_ready`=0 thereafter until reset.
- 17 pushes with DEPTH_BITS=4, check enabled → 17th gives `trap`=`CTRL_OVERFLOW` and `depth` stays 16; `br 5` at depth 2 → `CTRL_BAD_LABEL`.
- Reset pulsed during a `br 3` unwind → next cycle `depth`=0, `trap`=0, no `resp_valid`; `cmd_ready`=1 one cycle after reset drops.

Source files
------------

// File: rtl/control_stack_pkg.sv
// Shared types for the wasm control-frame stack: opcodes, frame kinds, value types and trap codes.
package control_stack_pkg;

    typedef enum logic [2:0] {
        CTRL_BLOCK = 3'd0,
        CTRL_LOOP  = 3'd1,
        CTRL_IF    = 3'd2,
        CTRL_ELSE  = 3'd3,
        CTRL_END   = 3'd4,
        CTRL_BR    = 3'd5
    } ctrl_op_e;

    typedef enum logic [1:0] {
        KIND_BLOCK = 2'd0,
        KIND_LOOP  = 2'd1,
        KIND_IF    = 2'd2
    } frame_kind_e;

    typedef enum logic [1:0] {
        VT_I32 = 2'd0,
        VT_I64 = 2'd1,
        VT_F32 = 2'd2,
        VT_F64 = 2'd3
    } val_type_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UNWIND = 2'd1,
        S_RESP   = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    localparam logic [3:0] TRAP_NONE      = 4'd0;
    localparam logic [3:0] TRAP_ENDED     = 4'd1;
    localparam logic [3:0] CTRL_OVERFLOW  = 4'd2;
    localparam logic [3:0] CTRL_BAD_ELSE  = 4'd3;
    localparam logic [3:0] CTRL_BAD_LABEL = 4'd4;

    function automatic frame_kind_e op_kind(ctrl_op_e op);
        case (op)
            CTRL_LOOP: return KIND_LOOP;
            CTRL_IF:   return KIND_IF;
            default:   return KIND_BLOCK;
        endcase
    endfunction

endpackage

// File: rtl/control_stack_if.sv
// Command/response bundle between the decoder/datapath (master) and the control stack (slave).
interface control_stack_if #(
    parameter int DEPTH_BITS = 4,
    parameter int PC_WIDTH   = 16,
    parameter int SP_WIDTH   = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic                  cmd_cond;
    logic [PC_WIDTH-1:0]   cmd_pc;
    logic [PC_WIDTH-1:0]   cmd_else_pc;
    logic [SP_WIDTH-1:0]   cmd_sp;
    logic [1:0]            cmd_type;
    logic                  cmd_has_result;
    logic [DEPTH_BITS-1:0] cmd_depth;

    logic                  resp_valid;
    logic                  resp_jump;
    logic [PC_WIDTH-1:0]   resp_pc;
    logic [SP_WIDTH-1:0]   resp_sp;
    logic [1:0]            resp_type;
    logic                  resp_has_result;
    logic [DEPTH_BITS:0]   depth;
    logic [3:0]            trap;

    modport master (
        output cmd_valid, cmd_op, cmd_cond, cmd_pc, cmd_else_pc, cmd_sp,
               cmd_type, cmd_has_result, cmd_depth,
        input  cmd_ready, resp_valid, resp_jump, resp_pc, resp_sp, resp_type,
               resp_has_result, depth, trap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cond, cmd_pc, cmd_else_pc, cmd_sp,
               cmd_type, cmd_has_result, cmd_depth,
        output cmd_ready, resp_valid, resp_jump, resp_pc, resp_sp, resp_type,
               resp_has_result, depth, trap
    );
endinterface

// File: rtl/control_stack_frame_ram.sv
// control_frame_ram: frame storage with one synchronous write port and one asynchronous read port.
module control_frame_ram #(
    parameter int DEPTH_BITS = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [DEPTH_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    logic [WIDTH-1:0] mem_q [2**DEPTH_BITS];

    // Contents are meaningless above the stack pointer, so no reset is needed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/control_stack.sv
// Control-frame stack and branch sequencer: resolves block/loop/if/else/end/br into PC/SP updates.
// Define CONTROL_STACK_CHECK_EN to enable overflow, bad-else and bad-label traps.
module control_stack
    import control_stack_pkg::*;
#(
    parameter int DEPTH_BITS = 4,
    parameter int PC_WIDTH   = 16,
    parameter int SP_WIDTH   = 8
) (
    input  logic            clk,
    input  logic            reset,
    control_stack_if.slave  bus
);
`ifdef CONTROL_STACK_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [DEPTH_BITS:0] FULL = (DEPTH_BITS+1)'(2**DEPTH_BITS);
    localparam logic [DEPTH_BITS:0] ONE  = (DEPTH_BITS+1)'(1);

    typedef struct packed {
        frame_kind_e         kind;
        logic [PC_WIDTH-1:0] pc;
        logic [SP_WIDTH-1:0] sp;
        val_type_e           vtype;
        logic                has_result;
    } frame_t;

    typedef struct packed {
        logic                jump;
        logic [PC_WIDTH-1:0] pc;
        logic [SP_WIDTH-1:0] sp;
        val_type_e           vtype;
        logic                has_result;
    } resp_t;

    state_e                state_q, state_d;
    logic [DEPTH_BITS:0]   depth_q, depth_d;
    logic [DEPTH_BITS-1:0] rem_q, rem_d;
    logic [3:0]            trap_q, trap_d;
    logic                  started_q;
    logic                  resp_vld_q, resp_vld_d;
    resp_t                 resp_q, resp_d;

    logic                  push_we;
    frame_t                push_frame;
    frame_t                top;
    logic [$bits(frame_t)-1:0] top_raw;
    logic                  accept;
    ctrl_op_e              op;

    assign op     = ctrl_op_e'(bus.cmd_op);
    assign accept = bus.cmd_valid && bus.cmd_ready;

    control_frame_ram #(
        .DEPTH_BITS (DEPTH_BITS),
        .WIDTH      ($bits(frame_t))
    ) u_frames (
        .clk     (clk),
        .we_i    (push_we && !reset),
        .waddr_i (depth_q[DEPTH_BITS-1:0]),
        .wdata_i (push_frame),
        .raddr_i (depth_q[DEPTH_BITS-1:0] - DEPTH_BITS'(1)),
        .rdata_o (top_raw)
    );
    assign top = frame_t'(top_raw);

    // A branch to a loop re-enters at its start, so no value crosses the restore.
    function automatic resp_t br_resp(frame_t f);
        resp_t r;
        r.jump       = 1'b1;
        r.pc         = f.pc;
        r.sp         = f.sp;
        r.vtype      = f.vtype;
        r.has_result = (f.kind == KIND_LOOP) ? 1'b0 : f.has_result;
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        rem_d      = rem_q;
        trap_d     = trap_q;
        resp_vld_d = 1'b0;
        resp_d     = resp_q;
        push_we    = 1'b0;

        push_frame.kind       = op_kind(op);
        push_frame.pc         = bus.cmd_pc;
        push_frame.sp         = bus.cmd_sp;
        push_frame.vtype      = val_type_e'(bus.cmd_type);
        push_frame.has_result = bus.cmd_has_result;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        CTRL_BLOCK, CTRL_LOOP, CTRL_IF: begin
                            if (CHECK_EN && depth_q == FULL) begin
                                trap_d  = CTRL_OVERFLOW;
                                state_d = S_HALT;
                            end else begin
                                push_we           = 1'b1;
                                depth_d           = depth_q + ONE;
                                resp_vld_d        = 1'b1;
                                resp_d.jump       = (op == CTRL_IF) && !bus.cmd_cond;
                                resp_d.pc         = resp_d.jump ? bus.cmd_else_pc : bus.cmd_pc;
                                resp_d.sp         = bus.cmd_sp;
                                resp_d.vtype      = push_frame.vtype;
                                resp_d.has_result = bus.cmd_has_result;
                            end
                        end
                        CTRL_ELSE: begin
                            if (CHECK_EN && (depth_q == '0 || top.kind != KIND_IF)) begin
                                trap_d  = CTRL_BAD_ELSE;
                                state_d = S_HALT;
                            end else begin
                                resp_vld_d        = 1'b1;
                                resp_d.jump       = 1'b1;
                                resp_d.pc         = top.pc;
                                resp_d.sp         = top.sp;
                                resp_d.vtype      = top.vtype;
                                resp_d.has_result = top.has_result;
                            end
                        end
                        CTRL_END: begin
                            if (depth_q == '0) begin
                                trap_d  = TRAP_ENDED;
                                state_d = S_HALT;
                            end else begin
                                depth_d           = depth_q - ONE;
                                resp_vld_d        = 1'b1;
                                resp_d.jump       = 1'b0;
                                resp_d.pc         = top.pc;
                                resp_d.sp         = top.sp;
                                resp_d.vtype      = top.vtype;
                                resp_d.has_result = top.has_result;
                            end
                        end
                        CTRL_BR: begin
                            if (CHECK_EN && {1'b0, bus.cmd_depth} >= depth_q) begin
                                trap_d  = CTRL_BAD_LABEL;
                                state_d = S_HALT;
                            end else if (bus.cmd_depth == '0) begin
                                resp_vld_d = 1'b1;
                                resp_d     = br_resp(top);
                                state_d    = S_RESP;
                            end else begin
                                depth_d = depth_q - ONE;
                                rem_d   = bus.cmd_depth - DEPTH_BITS'(1);
                                state_d = S_UNWIND;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_UNWIND: begin
                if (rem_q == '0) begin
                    resp_vld_d = 1'b1;
                    resp_d     = br_resp(top);
                    state_d    = S_RESP;
                end else begin
                    depth_d = depth_q - ONE;
                    rem_d   = rem_q - DEPTH_BITS'(1);
                end
            end
            // Holds cmd_ready low through the branch response cycle.
            S_RESP:  state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            depth_q    <= '0;
            rem_q      <= '0;
            trap_q     <= TRAP_NONE;
            started_q  <= 1'b0;
            resp_vld_q <= 1'b0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            rem_q      <= rem_d;
            trap_q     <= trap_d;
            started_q  <= 1'b1;
            resp_vld_q <= resp_vld_d;
            resp_q     <= resp_d;
        end
    end

    assign bus.cmd_ready       = started_q && !reset && (state_q == S_IDLE);
    assign bus.resp_valid      = resp_vld_q;
    assign bus.resp_jump       = resp_q.jump;
    assign bus.resp_pc         = resp_q.pc;
    assign bus.resp_sp         = resp_q.sp;
    assign bus.resp_type       = resp_q.vtype;
    assign bus.resp_has_result = resp_q.has_result;
    assign bus.depth           = depth_q;
    assign bus.trap            = trap_q;
endmodule

// File: tb/tb_control_stack.sv
// Scoreboard bench for control_stack: stimulus pushes expected responses, a negedge monitor checks them.
module tb_control_stack;
    import control_stack_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    control_stack_if #(.DEPTH_BITS(4), .PC_WIDTH(16), .SP_WIDTH(8)) bus ();
    control_stack #(.DEPTH_BITS(4), .PC_WIDTH(16), .SP_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        int         cyc;
        bit         jump;
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [1:0]  vt;
        bit         res;
        bit         fr;
        logic [4:0]  depth;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.resp_valid !== 1'b0) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp_valid=%b pc=%0h expected no response", bus.resp_valid, bus.resp_pc);
            end else begin
                e = sbq.pop_front();
                chk({e.tag, "_cycle"}, cyc, e.cyc);
                chk({e.tag, "_jump"}, bus.resp_jump, e.jump);
                if (e.jump) chk({e.tag, "_pc"}, bus.resp_pc, e.pc);
                if (e.fr) begin
                    chk({e.tag, "_sp"}, bus.resp_sp, e.sp);
                    chk({e.tag, "_type"}, bus.resp_type, e.vt);
                    chk({e.tag, "_has_result"}, bus.resp_has_result, e.res);
                end
                chk({e.tag, "_depth"}, bus.depth, e.depth);
            end
        end
    end

    function automatic exp_t mk(string tag, bit jump, logic [15:0] pc, logic [7:0] sp,
                                logic [1:0] vt, bit res, bit fr, logic [4:0] d);
        exp_t e;
        e.tag = tag; e.cyc = 0; e.jump = jump; e.pc = pc; e.sp = sp;
        e.vt = vt; e.res = res; e.fr = fr; e.depth = d;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send(logic [2:0] op, bit cond, logic [15:0] pc, logic [15:0] epc,
                        logic [7:0] sp, logic [1:0] vt, bit res, logic [3:0] n,
                        bit expv, exp_t e, int lat);
        int w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout_%s: got cmd_ready=%b expected 1", e.tag, bus.cmd_ready);
        end
        bus.cmd_op = op; bus.cmd_cond = cond; bus.cmd_pc = pc; bus.cmd_else_pc = epc;
        bus.cmd_sp = sp; bus.cmd_type = vt; bus.cmd_has_result = res; bus.cmd_depth = n;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (expv) begin
            e.cyc = cyc + lat;
            sbq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic push(string tag, logic [2:0] op, bit cond, logic [15:0] pc, logic [15:0] epc,
                        logic [7:0] sp, logic [1:0] vt, bit res, logic [4:0] d);
        send(op, cond, pc, epc, sp, vt, res, 4'd0, 1'b1,
             mk(tag, (op == CTRL_IF) && !cond, epc, sp, vt, res, 1'b0, d), 0);
    endtask

    task automatic end_cmd(string tag, logic [7:0] sp, logic [1:0] vt, bit res, logic [4:0] d);
        send(CTRL_END, 1'b0, 16'h0, 16'h0, 8'h0, 2'd0, 1'b0, 4'd0, 1'b1,
             mk(tag, 1'b0, 16'h0, sp, vt, res, 1'b1, d), 0);
    endtask

    task automatic br_cmd(string tag, logic [3:0] n, logic [15:0] pc, logic [7:0] sp,
                          logic [1:0] vt, bit res, logic [4:0] d);
        send(CTRL_BR, 1'b0, 16'h0, 16'h0, 8'h0, 2'd0, 1'b0, n, 1'b1,
             mk(tag, 1'b1, pc, sp, vt, res, 1'b1, d), int'(n));
    endtask

    task automatic no_resp(string tag, logic [2:0] op, logic [3:0] n);
        send(op, 1'b0, 16'h0, 16'h0, 8'h0, 2'd0, 1'b0, n, 1'b0,
             mk(tag, 1'b0, 16'h0, 8'h0, 2'd0, 1'b0, 1'b0, 5'd0), 0);
    endtask

    task automatic do_reset(string tag);
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_rst_ready"}, bus.cmd_ready, 0);
        chk({tag, "_rst_depth"}, bus.depth, 0);
        chk({tag, "_rst_trap"}, bus.trap, 0);
        chk({tag, "_rst_resp_valid"}, bus.resp_valid, 0);
        reset = 1'b0;
        chk({tag, "_ready_low_at_release"}, bus.cmd_ready, 0);
        @(negedge clk);
        chk({tag, "_ready_after_release"}, bus.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_cond = 1'b0; bus.cmd_pc = '0;
        bus.cmd_else_pc = '0; bus.cmd_sp = '0; bus.cmd_type = '0; bus.cmd_has_result = 1'b0;
        bus.cmd_depth = '0;
        @(negedge clk);
        do_reset("init");

        // if-false / else / end
        push("if_false", CTRL_IF, 1'b0, 16'h20, 16'h18, 8'd3, VT_I32, 1'b0, 5'd1);
        send(CTRL_ELSE, 1'b0, 16'h0, 16'h0, 8'h0, 2'd0, 1'b0, 4'd0, 1'b1,
             mk("else", 1'b1, 16'h20, 8'd0, 2'd0, 1'b0, 1'b0, 5'd1), 0);
        end_cmd("if_end", 8'd3, VT_I32, 1'b0, 5'd0);

        // br 1 out of a loop to an enclosing block
        push("block", CTRL_BLOCK, 1'b0, 16'h40, 16'h40, 8'd1, VT_I32, 1'b1, 5'd1);
        push("loop", CTRL_LOOP, 1'b0, 16'h10, 16'h10, 8'd2, VT_I64, 1'b0, 5'd2);
        br_cmd("br1", 4'd1, 16'h40, 8'd1, VT_I32, 1'b1, 5'd1);
        chk("br1_ready_t1", bus.cmd_ready, 0);
        @(negedge clk);
        chk("br1_ready_resp_cycle", bus.cmd_ready, 0);
        @(negedge clk);
        chk("br1_ready_after", bus.cmd_ready, 1);
        end_cmd("block_end", 8'd1, VT_I32, 1'b1, 5'd0);

        // br 0 to a loop
        push("loop2", CTRL_LOOP, 1'b0, 16'h10, 16'h10, 8'd2, VT_F32, 1'b1, 5'd1);
        br_cmd("br0", 4'd0, 16'h10, 8'd2, VT_F32, 1'b0, 5'd1);
        chk("br0_ready_resp_cycle", bus.cmd_ready, 0);
        end_cmd("loop2_end", 8'd2, VT_F32, 1'b1, 5'd0);

        // br 1 to a taken if frame
        push("outer", CTRL_BLOCK, 1'b0, 16'h100, 16'h100, 8'd5, VT_I32, 1'b0, 5'd1);
        push("if_true", CTRL_IF, 1'b1, 16'h80, 16'h80, 8'd6, VT_F64, 1'b1, 5'd2);
        push("inner", CTRL_BLOCK, 1'b0, 16'h70, 16'h70, 8'd7, VT_I64, 1'b0, 5'd3);
        br_cmd("br_if", 4'd1, 16'h80, 8'd6, VT_F64, 1'b1, 5'd2);
        @(negedge clk);
        end_cmd("if_true_end", 8'd6, VT_F64, 1'b1, 5'd1);
        end_cmd("outer_end", 8'd5, VT_I32, 1'b0, 5'd0);

        // reset during an unwind
        for (int i = 0; i < 4; i++)
            push("loop4", CTRL_LOOP, 1'b0, 16'h200, 16'h200, 8'(i), VT_I32, 1'b0, 5'(i + 1));
        no_resp("br3", CTRL_BR, 4'd3);
        chk("br3_depth_first_pop", bus.depth, 3);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_depth", bus.depth, 0);
        chk("abort_trap", bus.trap, 0);
        chk("abort_resp_valid", bus.resp_valid, 0);
        do_reset("abort");

        // 17 pushes
        for (int i = 0; i < 16; i++)
            push("fill", CTRL_BLOCK, 1'b0, 16'h300, 16'h300, 8'd0, VT_I32, 1'b0, 5'(i + 1));
`ifdef CONTROL_STACK_CHECK_EN
        no_resp("overflow", CTRL_BLOCK, 4'd0);
        chk("overflow_trap", bus.trap, CTRL_OVERFLOW);
        chk("overflow_depth", bus.depth, 16);
        chk("overflow_ready", bus.cmd_ready, 0);
        do_reset("ovf");

        push("else_blk", CTRL_BLOCK, 1'b0, 16'h50, 16'h50, 8'd1, VT_I32, 1'b0, 5'd1);
        no_resp("bad_else", CTRL_ELSE, 4'd0);
        chk("bad_else_trap", bus.trap, CTRL_BAD_ELSE);
        chk("bad_else_depth", bus.depth, 1);
        do_reset("belse");

        push("lbl_a", CTRL_BLOCK, 1'b0, 16'h60, 16'h60, 8'd1, VT_I32, 1'b0, 5'd1);
        push("lbl_b", CTRL_BLOCK, 1'b0, 16'h64, 16'h64, 8'd2, VT_I32, 1'b0, 5'd2);
        no_resp("bad_label", CTRL_BR, 4'd5);
        chk("bad_label_trap", bus.trap, CTRL_BAD_LABEL);
        chk("bad_label_depth", bus.depth, 2);
        chk("bad_label_ready", bus.cmd_ready, 0);
`else
        push("wrap", CTRL_BLOCK, 1'b0, 16'h300, 16'h300, 8'd0, VT_I32, 1'b0, 5'd17);
        chk("wrap_trap", bus.trap, 0);
`endif
        do_reset("pre_end");

        // end at depth 0 halts until reset
        no_resp("func_end", CTRL_END, 4'd0);
        chk("ended_trap", bus.trap, TRAP_ENDED);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ended_ready_low", bus.cmd_ready, 0);
            chk("ended_trap_sticky", bus.trap, TRAP_ENDED);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
